spi_slave_fifo: RTL and testbench

- Parametrised successor to the existing SUMP SPI slave front end. Oversampled SPI slave with all four CPOL/CPHA modes, configurable word width and bit order, internal RX and TX FIFOs with valid/ready handshakes, and sticky error status.
- Sits between the external SPI pins and the command decoder / sample transmitter.
- All logic runs in the system clock domain. SPI pins are synchronised internally.

---
 rtl/spi_slave_fifo.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_spi_slave_fifo.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_fifo.sv
// ----------------------------------------------------------------------------
// spi_slave_fifo
//   Oversampled SPI slave for the SUMP front end. SPI pins are synchronised
//   into the clk domain. All four CPOL/CPHA modes are supported. Received
//   words go to an RX FIFO and transmitted words come from a TX FIFO. Both
//   FIFOs use valid/ready handshakes. Error flags are sticky.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   spi_mode           {CPOL,CPHA}, latched when chip select falls
//   spi_cs_n/sclk/mosi raw SPI pins (asynchronous to clk)
//   spi_miso, _oe      registered slave output and its drive enable
//   rx_data/valid/rdy  RX FIFO head, first-word-fall-through
//   tx_data/valid/rdy  TX FIFO push side
//   rx_level/tx_level  FIFO occupancy
//   busy               synchronised chip select is active
//   status             sticky {frame_err, tx_underrun, rx_overflow}
//   clr_status         one-cycle pulse clears status (new events win)
// ----------------------------------------------------------------------------

// Synchronous first-word-fall-through FIFO. Pointers carry one extra MSB so
// that full and empty can be told apart. A pop frees a slot in the same
// cycle, so a push into a full FIFO is taken while the head is being popped.
module spi_slave_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // The head reads as zero while empty so the RX output is clean after reset.
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; both wrap naturally through the extra MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; it is only observed through a valid head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

module spi_slave_fifo #(
  parameter int                DATA_W      = 8,
  parameter int                RX_DEPTH    = 16,
  parameter int                TX_DEPTH    = 16,
  parameter int                SYNC_STAGES = 2,
  parameter int                MSB_FIRST   = 1,
  parameter logic [DATA_W-1:0] IDLE_WORD   = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                spi_mode,
  input  logic                      spi_cs_n,
  input  logic                      spi_sclk,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic                      spi_miso_oe,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic                      busy,
  output logic [2:0]                status,
  input  logic                      clr_status
);
  localparam int               CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(DATA_W);

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync;
  logic [SYNC_STAGES-1:0]  cs_sync;
  logic [SYNC_STAGES-1:0]  mosi_sync;
  logic                    sclk_d;
  logic                    cs_d;
  logic                    sclk_s;
  logic                    cs_s;
  logic                    mosi_s;

  logic [1:0]              mode_q;
  logic [DATA_W-1:0]       tx_shift;
  logic [DATA_W-1:0]       rx_shift;
  logic [CW-1:0]           bit_cnt;
  logic                    first_shift;
  logic                    underrun_pend;

  logic                    cpol;
  logic                    cpha;
  logic                    leading;
  logic                    trailing;
  logic                    sample_edge;
  logic                    shift_edge;
  logic                    cs_fall;
  logic                    in_word;
  logic                    reload;
  logic                    tx_pop;
  logic [DATA_W-1:0]       load_word;
  logic [DATA_W-1:0]       next_shift;
  logic                    rx_push;
  logic                    ev_overflow;
  logic                    ev_underrun;
  logic                    ev_frame;

  logic [DATA_W-1:0]       tx_head;
  logic                    tx_empty;
  logic                    tx_full;
  logic                    rx_empty;
  logic                    rx_full;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  // Pin synchronisers plus one extra copy for edge detection. Presets match
  // an idle, deselected bus so no edge is seen coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edge classification uses the mode latched at chip-select fall. A reload
  // happens on a shift edge with no bits counted, except the very first
  // shift edge of a selection (CPHA=1 keeps the word loaded in LOAD).
  always_comb begin
    cpol        = mode_q[1];
    cpha        = mode_q[0];
    leading     = (sclk_s != sclk_d) && (sclk_s != cpol);
    trailing    = (sclk_s != sclk_d) && (sclk_s == cpol);
    sample_edge = cpha ? trailing : leading;
    shift_edge  = cpha ? leading  : trailing;
    cs_fall     = !cs_s && cs_d;
    in_word     = (state == ACTIVE) && !cs_s;
    reload      = in_word && shift_edge && (bit_cnt == '0) && !first_shift;
    tx_pop      = ((state == LOAD) || reload) && !tx_empty;
    load_word   = tx_empty ? IDLE_WORD : tx_head;
    next_shift  = shift_out(tx_shift);
    rx_push     = (state == ACTIVE) && (bit_cnt == FULL_CNT);
    ev_overflow = rx_push && rx_full && !(rx_valid && rx_ready);
    // A filler word reloaded after the last bit is only an underrun once the
    // master actually clocks a bit of it; LOAD always flags immediately.
    ev_underrun = ((state == LOAD) && tx_empty) ||
                  (in_word && sample_edge && underrun_pend);
    ev_frame    = (state == ACTIVE) && cs_s && (bit_cnt != '0) && (bit_cnt != FULL_CNT);
  end

  // Transfer state machine with registered MISO, drive enable and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mode_q        <= 2'b00;
      busy          <= 1'b0;
      spi_miso_oe   <= 1'b0;
      spi_miso      <= 1'b0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      bit_cnt       <= '0;
      first_shift   <= 1'b0;
      underrun_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            mode_q <= spi_mode;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          tx_shift      <= load_word;
          spi_miso      <= first_bit(load_word);
          spi_miso_oe   <= 1'b1;
          first_shift   <= 1'b1;
          bit_cnt       <= '0;
          underrun_pend <= 1'b0;
          state         <= ACTIVE;
        end
        ACTIVE: begin
          if (cs_s) begin
            state         <= IDLE;
            spi_miso_oe   <= 1'b0;
            spi_miso      <= 1'b0;
            busy          <= 1'b0;
            bit_cnt       <= '0;
            underrun_pend <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_shift      <= shift_in(rx_shift, mosi_s);
              bit_cnt       <= bit_cnt + 1'b1;
              underrun_pend <= 1'b0;
            end else if (bit_cnt == FULL_CNT) begin
              bit_cnt <= '0;
            end
            if (shift_edge) begin
              first_shift <= 1'b0;
              if (reload) begin
                tx_shift      <= load_word;
                spi_miso      <= first_bit(load_word);
                underrun_pend <= tx_empty;
              end else if (bit_cnt != '0) begin
                tx_shift <= next_shift;
                spi_miso <= first_bit(next_shift);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error flags; an event in the clearing cycle still sets its bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status <= 3'b000;
    end else begin
      status <= (clr_status ? 3'b000 : status) | {ev_frame, ev_underrun, ev_overflow};
    end
  end

  spi_slave_fifo_buf #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_ready),
    .head      (rx_data),
    .empty     (rx_empty),
    .full      (rx_full),
    .level     (rx_level)
  );

  spi_slave_fifo_buf #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_valid && tx_ready),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .empty     (tx_empty),
    .full      (tx_full),
    .level     (tx_level)
  );

  assign rx_valid = !rx_empty;
  assign tx_ready = !tx_full;
endmodule

// File: tb/tb_spi_slave_fifo.sv
// ----------------------------------------------------------------------------
// tb_spi_slave_fifo
//   Bench for spi_slave_fifo. It models an SPI master and keeps scoreboards of
//   the expected RX words and MISO words. Two DUTs share the SPI bus: u_dut is
//   MSB-first with IDLE_WORD=0xFF, and u_dut2 is LSB-first. Each DUT has its
//   own chip select.
// ----------------------------------------------------------------------------
module tb_spi_slave_fifo;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] spi_mode;
  logic       cs_n, cs_n2, sclk, mosi;
  logic       miso, oe, miso2, oe2;
  logic [7:0] rx_data, rx_data2, tx_data;
  logic       rx_valid, rx_valid2, rx_ready, rx_ready2;
  logic       tx_valid, tx_valid2, tx_ready, tx_ready2;
  logic [4:0] rx_level, tx_level, rx_level2, tx_level2;
  logic       busy, busy2, clr_status;
  logic [2:0] status, status2;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];

  always #5 clk = ~clk;

  spi_slave_fifo #(.DATA_W(8), .RX_DEPTH(16), .TX_DEPTH(16), .SYNC_STAGES(2),
                   .MSB_FIRST(1), .IDLE_WORD(8'hFF)) u_dut (
    .clk(clk), .rst_n(rst_n), .spi_mode(spi_mode), .spi_cs_n(cs_n),
    .spi_sclk(sclk), .spi_mosi(mosi), .spi_miso(miso), .spi_miso_oe(oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_level(rx_level), .tx_level(tx_level), .busy(busy),
    .status(status), .clr_status(clr_status)
  );

  spi_slave_fifo #(.DATA_W(8), .RX_DEPTH(16), .TX_DEPTH(16), .SYNC_STAGES(2),
                   .MSB_FIRST(0), .IDLE_WORD(8'h00)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .spi_mode(spi_mode), .spi_cs_n(cs_n2),
    .spi_sclk(sclk), .spi_mosi(mosi), .spi_miso(miso2), .spi_miso_oe(oe2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
    .tx_data(tx_data), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .rx_level(rx_level2), .tx_level(tx_level2), .busy(busy2),
    .status(status2), .clr_status(clr_status)
  );

  // Hard stop in case a handshake never completes.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [25:0] snapshot();
    return {miso, oe, rx_valid, tx_ready, rx_level, tx_level, busy, status, rx_data};
  endfunction

  localparam logic [25:0] RESET_SNAP = {1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 3'd0, 8'd0};

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input int sel, input logic [7:0] w);
    int k;
    k = 0;
    while (!(sel == 1 ? tx_ready2 : tx_ready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    tx_data = w;
    if (sel == 1) tx_valid2 = 1'b1; else tx_valid = 1'b1;
    @(negedge clk);
    tx_valid  = 1'b0;
    tx_valid2 = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_begin(input int sel, input logic [1:0] mode);
    spi_mode = mode;
    sclk     = mode[1];
    wait_clks(4);
    if (sel == 1) cs_n2 = 1'b0; else cs_n = 1'b0;
    wait_clks(2);
  endtask

  task automatic cs_end(input int sel);
    wait_clks(H);
    if (sel == 1) cs_n2 = 1'b1; else cs_n = 1'b1;
    wait_clks(8);
  endtask

  // One word (or a partial word) from the master's point of view.
  task automatic spi_word(input int sel, input logic [1:0] mode, input logic [7:0] mo,
                          input int nbits, output logic [7:0] mi);
    logic cpol, cpha;
    int idx;
    cpol = mode[1];
    cpha = mode[0];
    mi   = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = (sel == 1) ? i : 7 - i;
      if (!cpha) begin
        mosi = mo[idx];
        wait_clks(H);
        sclk = ~cpol;
        mi[idx] = (sel == 1) ? miso2 : miso;
        wait_clks(H);
        sclk = cpol;
      end else begin
        wait_clks(H);
        sclk = ~cpol;
        mosi = mo[idx];
        wait_clks(H);
        sclk = cpol;
        mi[idx] = (sel == 1) ? miso2 : miso;
      end
    end
  endtask

  task automatic pop_check(input int sel, input string name);
    logic [7:0] e;
    int k;
    k = 0;
    while (!(sel == 1 ? rx_valid2 : rx_valid) && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!(sel == 1 ? rx_valid2 : rx_valid)) begin
      errors++;
      $display("[TB] FAIL %s: rx_valid never rose", name);
    end else if (exp_rx.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: unexpected RX word %h", name, sel == 1 ? rx_data2 : rx_data);
    end else begin
      e = exp_rx.pop_front();
      if ((sel == 1 ? rx_data2 : rx_data) !== e) begin
        errors++;
        $display("[TB] FAIL %s: rx_data got %h want %h", name, sel == 1 ? rx_data2 : rx_data, e);
      end
      if (sel == 1) rx_ready2 = 1'b1; else rx_ready = 1'b1;
      @(negedge clk);
      rx_ready  = 1'b0;
      rx_ready2 = 1'b0;
    end
  endtask

  task automatic miso_check(input logic [7:0] got, input string name);
    logic [7:0] e;
    checks++;
    if (exp_miso.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: no expected MISO word, got %h", name, got);
    end else begin
      e = exp_miso.pop_front();
      if (got !== e) begin
        errors++;
        $display("[TB] FAIL %s: miso word got %h want %h", name, got, e);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (snapshot() !== RESET_SNAP) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h want %h", snapshot(), RESET_SNAP);
    end
    rst_n = 1'b1;
    wait_clks(4);
    checks++;
    if (snapshot() !== RESET_SNAP) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got %h want %h", snapshot(), RESET_SNAP);
    end
  endtask

  task automatic test_mode0();
    logic [7:0] mi;
    push_tx(0, 8'hA5);
    exp_miso.push_back(8'hA5);
    exp_rx.push_back(8'h3C);
    cs_begin(0, 2'b00);
    spi_word(0, 2'b00, 8'h3C, 8, mi);
    checks++;
    if ({busy, oe} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL mode0_busy_oe: got %b want 11", {busy, oe});
    end
    cs_end(0);
    miso_check(mi, "mode0_miso");
    checks++;
    if ({busy, oe, status} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL mode0_status: busy/oe/status got %b want 00000", {busy, oe, status});
    end
    pop_check(0, "mode0_rx");
  endtask

  task automatic test_modes();
    logic [7:0] mi;
    for (int m = 1; m <= 3; m++) begin
      push_tx(0, 8'h12);
      push_tx(0, 8'h34);
      exp_miso.push_back(8'h12);
      exp_miso.push_back(8'h34);
      exp_rx.push_back(8'hC3);
      exp_rx.push_back(8'h5A);
      cs_begin(0, 2'(m));
      spi_word(0, 2'(m), 8'hC3, 8, mi);
      miso_check(mi, $sformatf("mode%0d_miso0", m));
      spi_word(0, 2'(m), 8'h5A, 8, mi);
      miso_check(mi, $sformatf("mode%0d_miso1", m));
      cs_end(0);
      checks++;
      if ({tx_level, status} !== 8'h00) begin
        errors++;
        $display("[TB] FAIL mode%0d_level_status: tx_level %0d status %b want 0 000", m, tx_level, status);
      end
      pop_check(0, $sformatf("mode%0d_rx0", m));
      pop_check(0, $sformatf("mode%0d_rx1", m));
    end
  endtask

  task automatic test_underrun();
    logic [7:0] mi;
    exp_miso.push_back(8'hFF);
    exp_rx.push_back(8'h81);
    cs_begin(0, 2'b00);
    spi_word(0, 2'b00, 8'h81, 8, mi);
    cs_end(0);
    miso_check(mi, "underrun_miso");
    checks++;
    if (status !== 3'b010) begin
      errors++;
      $display("[TB] FAIL underrun_status: got %b want 010", status);
    end
    pop_check(0, "underrun_rx");
    pulse_clr();
    checks++;
    if (status !== 3'b000) begin
      errors++;
      $display("[TB] FAIL underrun_clear: got %b want 000", status);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] mi;
    logic [7:0] w;
    cs_begin(0, 2'b00);
    for (int i = 0; i < 17; i++) begin
      w = 8'(i * 29 + 7);
      if (i < 16) exp_rx.push_back(w);
      spi_word(0, 2'b00, w, 8, mi);
    end
    cs_end(0);
    checks++;
    if (rx_level !== 5'd16) begin
      errors++;
      $display("[TB] FAIL overflow_level: got %0d want 16", rx_level);
    end
    checks++;
    if (status[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_flag: status got %b want xx1", status);
    end
    for (int i = 0; i < 16; i++) pop_check(0, $sformatf("overflow_drain%0d", i));
    checks++;
    if (rx_level !== 5'd0) begin
      errors++;
      $display("[TB] FAIL overflow_empty: rx_level got %0d want 0", rx_level);
    end
    pulse_clr();
  endtask

  task automatic test_frame();
    logic [7:0] mi;
    cs_begin(0, 2'b00);
    spi_word(0, 2'b00, 8'hFF, 5, mi);
    cs_end(0);
    checks++;
    if ({rx_level, status[2]} !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL frame_err: rx_level %0d frame_err %b want 0 1", rx_level, status[2]);
    end
    pulse_clr();
    push_tx(0, 8'h5C);
    exp_miso.push_back(8'h5C);
    exp_rx.push_back(8'h96);
    cs_begin(0, 2'b00);
    spi_word(0, 2'b00, 8'h96, 8, mi);
    cs_end(0);
    miso_check(mi, "frame_next_miso");
    checks++;
    if (status !== 3'b000) begin
      errors++;
      $display("[TB] FAIL frame_next_status: got %b want 000", status);
    end
    pop_check(0, "frame_next_rx");
  endtask

  task automatic test_reset_midword();
    logic [7:0] mi;
    push_tx(0, 8'h11);
    cs_begin(0, 2'b00);
    spi_word(0, 2'b00, 8'hE7, 8, mi);
    cs_end(0);
    push_tx(0, 8'h33);
    push_tx(0, 8'h44);
    cs_begin(0, 2'b00);
    spi_word(0, 2'b00, 8'h0F, 3, mi);
    rst_n = 1'b0;
    #1;
    checks++;
    if (snapshot() !== RESET_SNAP) begin
      errors++;
      $display("[TB] FAIL midword_reset: got %h want %h", snapshot(), RESET_SNAP);
    end
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(3);
    exp_rx.delete();
    exp_miso.delete();
    push_tx(1, 8'h01);
    exp_miso.push_back(8'h01);
    exp_rx.push_back(8'h5A);
    cs_begin(1, 2'b00);
    spi_word(1, 2'b00, 8'h5A, 8, mi);
    cs_end(1);
    checks++;
    if (mi[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lsb_first_bit: got %b want 1", mi[0]);
    end
    miso_check(mi, "lsb_miso");
    pop_check(1, "lsb_rx");
  endtask

  initial begin
    rst_n      = 1'b0;
    spi_mode   = 2'b00;
    cs_n       = 1'b1;
    cs_n2      = 1'b1;
    sclk       = 1'b0;
    mosi       = 1'b0;
    rx_ready   = 1'b0;
    rx_ready2  = 1'b0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    tx_valid2  = 1'b0;
    clr_status = 1'b0;
    wait_clks(3);
    $display("[TB] starting");
    test_reset();
    test_mode0();
    test_modes();
    test_underrun();
    test_overflow();
    test_frame();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
